// File: rtl/pockstat_lcd_video.sv
// PocketStation LCD video output: scans the 32x32 mono frame, fetches one LCD row per
// SCALE output lines into a line buffer and produces upscaled sync, blank and RGB video.
module pockstat_lcd_video #(
    parameter int SCALE  = 8,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 32,
    parameter int H_BP   = 48,
    parameter int V_FP   = 4,
    parameter int V_SYNC = 4,
    parameter int V_BP   = 16,
    parameter int CE_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ce_pix,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        fb_rd_req,
    output logic [4:0]  fb_rd_row,
    input  logic        fb_rd_ack,
    input  logic [31:0] fb_rd_data,
    output logic        frame_start,
    output logic        underrun
);
    localparam int ACT   = 32 * SCALE;
    localparam int H_TOT = ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = ACT + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = $clog2(CE_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(ACT);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] HS_BEG   = HW'(ACT + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(ACT + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_SCALE  = HW'(SCALE);
    localparam logic [VW-1:0] V_ACT    = VW'(ACT);
    localparam logic [VW-1:0] V_ACT_M1 = VW'(ACT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(ACT + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(ACT + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_SCALE  = VW'(SCALE);
    localparam logic [23:0]   DARK     = 24'h202820;
    localparam logic [23:0]   LIGHT    = 24'hB0C0A0;

    typedef enum logic {IDLE, REQ} fetch_state_t;

    fetch_state_t  state_reg;
    logic [DW-1:0] div_reg;
    logic          ce_reg;
    logic [HW-1:0] hcnt_reg;
    logic [VW-1:0] vcnt_reg;
    logic          hsync_reg;
    logic          vsync_reg;
    logic          hblank_reg;
    logic          vblank_reg;
    logic          frame_start_reg;
    logic          req_reg;
    logic          underrun_reg;
    logic [23:0]   rgb_reg;
    logic [4:0]    row_reg;
    logic [31:0]   linebuf_reg;
    logic [31:0]   linebuf_next;

    logic          ack_take;
    logic          active;
    logic          pixel_on;
    logic          h_wrap;
    logic          fetch_hit;
    logic [VW-1:0] next_line;
    logic [4:0]    col;

    // An ack landing on the first pixel of a line must already be visible on that
    // pixel, so the colour lookup reads the buffer's next value, not its current one.
    always_comb begin
        ack_take     = (state_reg == REQ) && fb_rd_ack;
        linebuf_next = ack_take ? fb_rd_data : linebuf_reg;
        col          = 5'(hcnt_reg / H_SCALE);
        active       = (hcnt_reg < H_ACT) && (vcnt_reg < V_ACT);
        pixel_on     = linebuf_next[col];
        h_wrap       = (hcnt_reg == H_LAST);
        next_line    = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + VW'(1);
        fetch_hit    = (hcnt_reg == H_ACT) && (next_line < V_ACT) &&
                       ((next_line % V_SCALE) == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            div_reg         <= '0;
            ce_reg          <= 1'b0;
            hcnt_reg        <= '0;
            vcnt_reg        <= '0;
            hsync_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            hblank_reg      <= 1'b0;
            vblank_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            req_reg         <= 1'b0;
            underrun_reg    <= 1'b0;
            rgb_reg         <= '0;
            row_reg         <= '0;
            linebuf_reg     <= '0;
        end else begin
            div_reg         <= (div_reg == DIV_LAST) ? '0 : div_reg + DW'(1);
            ce_reg          <= (div_reg == DIV_LAST);
            frame_start_reg <= 1'b0;
            linebuf_reg     <= linebuf_next;

            if (ce_reg) begin
                hblank_reg      <= (hcnt_reg >= H_ACT);
                vblank_reg      <= (vcnt_reg >= V_ACT);
                hsync_reg       <= (hcnt_reg >= HS_BEG) && (hcnt_reg < HS_END);
                vsync_reg       <= (vcnt_reg >= VS_BEG) && (vcnt_reg < VS_END);
                rgb_reg         <= !active ? 24'h0 : (pixel_on ? DARK : LIGHT);
                frame_start_reg <= h_wrap && (vcnt_reg == V_ACT_M1);
                if (h_wrap) begin
                    hcnt_reg <= '0;
                    vcnt_reg <= next_line;
                end else begin
                    hcnt_reg <= hcnt_reg + HW'(1);
                end
            end

            // The fetch for a line group is issued at the start of the previous
            // line's blanking and must complete before the next line's first pixel.
            case (state_reg)
                IDLE: begin
                    if (ce_reg && fetch_hit) begin
                        row_reg   <= 5'(next_line / V_SCALE);
                        req_reg   <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (ack_take) begin
                        req_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end else if (ce_reg && hcnt_reg == '0) begin
                        req_reg      <= 1'b0;
                        underrun_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
            endcase
        end
    end

    assign ce_pix      = ce_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign hblank      = hblank_reg;
    assign vblank      = vblank_reg;
    assign r           = rgb_reg[23:16];
    assign g           = rgb_reg[15:8];
    assign b           = rgb_reg[7:0];
    assign fb_rd_req   = req_reg;
    assign fb_rd_row   = row_reg;
    assign frame_start = frame_start_reg;
    assign underrun    = underrun_reg;
endmodule

// File: tb/tb_pockstat_lcd_video.sv
// Bench for pockstat_lcd_video with a reduced raster: cycle-accurate reference model
// derived from cycle count, a randomized acking row source and a pixel-map probe table.
module tb_pockstat_lcd_video;
    localparam int SC  = 2;
    localparam int HFP = 4;
    localparam int HSY = 8;
    localparam int HBP = 12;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 4;
    localparam int CED = 3;
    localparam int ACT = 32 * SC;
    localparam int HT  = ACT + HFP + HSY + HBP;
    localparam int VT  = ACT + VFP + VSY + VBP;
    localparam int WIN = (HT - ACT) * CED;
    localparam logic [23:0] DARK  = 24'h202820;
    localparam logic [23:0] LIGHT = 24'hB0C0A0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fb_rd_ack = 1'b0;
    logic [31:0] fb_rd_data = '0;
    logic        ce_pix, hsync, vsync, hblank, vblank;
    logic        fb_rd_req, frame_start, underrun;
    logic [7:0]  r, g, b;
    logic [4:0]  fb_rd_row;

    pockstat_lcd_video #(
        .SCALE(SC), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .CE_DIV(CED)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .r(r), .g(g), .b(b),
        .fb_rd_req(fb_rd_req), .fb_rd_row(fb_rd_row),
        .fb_rd_ack(fb_rd_ack), .fb_rd_data(fb_rd_data),
        .frame_start(frame_start), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          line;
        int          pix;
        logic [23:0] rgb;
        logic [3:0]  fl;
    } probe_t;

    int          total = 0;
    int          bad = 0;
    int          n = 0;
    logic [31:0] rows [32];
    logic [31:0] lb;
    logic        e_req, e_unr, e_fs;
    logic [4:0]  e_row;
    logic [27:0] e_vid;
    logic        ack_drv, prev_req, withheld;
    logic [31:0] data_drv;
    int          age, delay, cur_frame;
    logic [27:0] cap [2][VT][HT];
    probe_t      tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
        end
    endtask

    function automatic logic [27:0] vid_of(input int p, input logic [31:0] lbv);
        int h, v;
        logic [23:0] c;
        h = p % HT;
        v = (p / HT) % VT;
        if (h < ACT && v < ACT) c = lbv[h / SC] ? DARK : LIGHT;
        else c = 24'h0;
        return {h >= ACT, v >= ACT, (h >= ACT + HFP) && (h < ACT + HFP + HSY),
                (v >= ACT + VFP) && (v < ACT + VFP + VSY), c};
    endfunction

    task automatic model_reset();
        n = 0; lb = '0; e_req = 1'b0; e_unr = 1'b0; e_fs = 1'b0; e_row = '0; e_vid = '0;
        ack_drv = 1'b0; prev_req = 1'b0; withheld = 1'b0; age = 0; delay = 0; cur_frame = 0;
        data_drv = '0; fb_rd_ack = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_video"}, 32'({ce_pix, hblank, vblank, hsync, vsync, r, g, b}), 32'h0);
        chk({tag, "_ctl"}, 32'({fb_rd_req, fb_rd_row, frame_start, underrun}), 32'h0);
    endtask

    // One clock: advance the reference, compare every output, then drive the row source.
    task automatic cycle();
        bit ce_st;
        int q, nv;
        @(posedge clk);
        n++;
        #1;
        ce_st = (n - 1 >= CED) && ((n - 1) % CED == 0);
        q = ce_st ? (n - 1) / CED - 1 : 0;
        e_fs = 1'b0;
        if (ack_drv && e_req) begin
            lb = data_drv;
            e_req = 1'b0;
        end else if (e_req && ce_st && q % HT == 0) begin
            e_req = 1'b0;
            e_unr = 1'b1;
        end else if (!e_req && ce_st && q % HT == ACT) begin
            nv = ((q / HT) % VT + 1) % VT;
            if (nv < ACT && nv % SC == 0) begin
                e_req = 1'b1;
                e_row = 5'(nv / SC);
            end
        end
        if (ce_st) begin
            e_vid = vid_of(q, lb);
            e_fs = (q % HT == HT - 1) && ((q / HT) % VT == ACT - 1);
            cur_frame = q / (HT * VT);
            if (cur_frame == 1 || cur_frame == 2)
                cap[cur_frame - 1][(q / HT) % VT][q % HT] = {hblank, vblank, hsync, vsync, r, g, b};
        end
        chk("ce_pix", 32'(ce_pix), 32'(n >= CED && n % CED == 0));
        chk("video", 32'({hblank, vblank, hsync, vsync, r, g, b}), 32'(e_vid));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("fb_rd_req", 32'(fb_rd_req), 32'(e_req));
        if (e_req) chk("fb_rd_row", 32'(fb_rd_row), 32'(e_row));
        chk("underrun", 32'(underrun), 32'(e_unr));

        if (ce_st && q == ACT * HT)
            for (int i = 0; i < 32; i++) rows[i] = (i == 5) ? 32'h1 : 32'h0;
        if (ce_st && q == HT * VT + ACT * HT)
            for (int i = 0; i < 32; i++) rows[i] = $urandom();

        ack_drv = 1'b0;
        data_drv = $urandom();
        if (fb_rd_req) begin
            if (!prev_req) begin
                age = 0;
                if (cur_frame == 2 && fb_rd_row == 5'd3) begin
                    delay = 1 << 20;
                    withheld = 1'b1;
                end else if (cur_frame == 2 && fb_rd_row == 5'd6) begin
                    delay = WIN - 1;
                end else if ($urandom_range(0, 3) == 0) begin
                    delay = WIN - 1;
                end else begin
                    delay = $urandom_range(0, WIN - 1);
                end
            end else begin
                age++;
            end
            if (age == delay) begin
                ack_drv = 1'b1;
                data_drv = rows[fb_rd_row];
            end
        end else if (prev_req && withheld) begin
            ack_drv = 1'b1;
            data_drv = 32'hFFFF_FFFF;
            withheld = 1'b0;
        end else if ($urandom_range(0, 63) == 0) begin
            ack_drv = 1'b1;
        end
        prev_req = fb_rd_req;
        fb_rd_ack = ack_drv;
        fb_rd_data = data_drv;
    endtask

    initial begin
        int waited;
        logic [23:0] exp_rgb;
        tbl[0]  = '{10,  0, DARK,  4'b0000};
        tbl[1]  = '{11,  1, DARK,  4'b0000};
        tbl[2]  = '{10,  2, LIGHT, 4'b0000};
        tbl[3]  = '{ 9,  0, LIGHT, 4'b0000};
        tbl[4]  = '{12,  1, LIGHT, 4'b0000};
        tbl[5]  = '{ 0,  0, LIGHT, 4'b0000};
        tbl[6]  = '{63, 63, LIGHT, 4'b0000};
        tbl[7]  = '{10, 64, 24'h0, 4'b1000};
        tbl[8]  = '{10, 68, 24'h0, 4'b1010};
        tbl[9]  = '{10, 75, 24'h0, 4'b1010};
        tbl[10] = '{10, 76, 24'h0, 4'b1000};
        tbl[11] = '{66,  0, 24'h0, 4'b0101};
        tbl[12] = '{67, 87, 24'h0, 4'b1101};
        tbl[13] = '{68, 10, 24'h0, 4'b0100};
        tbl[14] = '{65, 67, 24'h0, 4'b1100};
        tbl[15] = '{65, 63, 24'h0, 4'b0100};
        for (int i = 0; i < 32; i++) rows[i] = $urandom();
        model_reset();

        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_zero("reset_hold");
        end
        reset_n = 1'b1;
        model_reset();

        // Frame 0 random, frame 1 pixel map, frame 2 withheld and edge acks.
        for (int i = 0; i < 3 * HT * VT * CED + 4 * CED; i++) cycle();

        for (int i = 0; i < 16; i++) begin
            chk("map_rgb", 32'(cap[0][tbl[i].line][tbl[i].pix][23:0]), 32'(tbl[i].rgb));
            chk("map_flags", 32'(cap[0][tbl[i].line][tbl[i].pix][27:24]), 32'(tbl[i].fl));
        end
        for (int h = 0; h < ACT; h += 9) begin
            exp_rgb = rows[2][h / SC] ? DARK : LIGHT;
            chk("stale_row2", 32'(cap[1][3 * SC][h][23:0]), 32'(exp_rgb));
            exp_rgb = rows[6][h / SC] ? DARK : LIGHT;
            chk("edge_ack_row6", 32'(cap[1][6 * SC][h][23:0]), 32'(exp_rgb));
        end
        chk("underrun_sticky", 32'(underrun), 32'h1);

        waited = 0;
        while (fb_rd_req !== 1'b1 && waited < 4 * HT * SC * CED) begin
            cycle();
            waited++;
        end
        chk("req_before_reset", 32'(fb_rd_req), 32'h1);
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_zero("reset_mid");
        end
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4 * HT * CED; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pockstat_lcd_video.md
# pockstat_lcd_video

Video output stage for the PocketStation core. It scans the 32x32 monochrome LCD frame held by the core, fetching one LCD row per group of scaled video lines over a request/acknowledge port into a local line buffer. It generates pixel clock enable, sync, blanking and 24-bit RGB for the MiSTer video outputs (`CE_PIXEL`, `VGA_*`). Each LCD pixel is scaled to SCALE×SCALE output pixels.

## Interface
Parameters:
- `SCALE`, 8: integer upscale factor. Active area is 32·SCALE × 32·SCALE, referred to below as ACT.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 32: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels. H_TOT = ACT+H_FP+H_SYNC+H_BP = 352.
- `V_FP`, 4: vertical front porch, in lines.
- `V_SYNC`, 4: vertical sync width, in lines.
- `V_BP`, 16: vertical back porch, in lines. V_TOT = 280.
- `CE_DIV`, 4: `clk` cycles per pixel. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock. One clock; all logic is in this domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ce_pix`  out  1  pixel enable. One `clk` pulse every CE_DIV cycles.
- `hsync`, `vsync`  out  1  active-high sync.
- `hblank`, `vblank`  out  1  blanking flags.
- `r`, `g`, `b`  out  8 each  pixel colour.
- `fb_rd_req`  out  1  row fetch request. Level signal.
- `fb_rd_row`  out  5  LCD row being requested.
- `fb_rd_ack`  in  1  single-cycle acknowledge. `fb_rd_data` is valid in the same cycle.
- `fb_rd_data`  in  32  row bits. Bit 0 is the leftmost pixel; 1 = pixel on.
- `frame_start`  out  1  one-`clk` pulse at vblank entry.
- `underrun`  out  1  sticky flag: a row fetch missed its deadline.

## Operation
- **Pixel enable divider.**
  - A counter runs 0..CE_DIV-1.
  - `ce_pix` is high when the counter equals CE_DIV-1.
- **Scan counters.**
  - `hcnt` runs 0..H_TOT-1 and `vcnt` runs 0..V_TOT-1.
  - Both advance only on `ce_pix`. `vcnt` increments when `hcnt` wraps.
- **Output stage.** On each `ce_pix` cycle the outputs are registered from the current counter values, then the counters advance. Outputs hold between `ce_pix` pulses.
  - `hblank` = `hcnt` ≥ ACT.
  - `vblank` = `vcnt` ≥ ACT.
  - `hsync` = `hcnt` ∈ [ACT+H_FP, ACT+H_FP+H_SYNC).
  - `vsync` = `vcnt` ∈ [ACT+V_FP, ACT+V_FP+V_SYNC).
- **Pixel colour.**
  - Inside the active area, column c = `hcnt`/SCALE selects bit `linebuf[c]`.
  - Bit = 1 → (0x20,0x28,0x20) dark.
  - Bit = 0 → (0xB0,0xC0,0xA0) light.
  - Outside the active area → (0,0,0).
- **Fetch state machine.** States: IDLE, REQ.
  - **Trigger.** In IDLE, on the `ce_pix` where `hcnt` == ACT, compute the next line nv = (`vcnt`+1) mod V_TOT.
    - If nv < ACT and nv mod SCALE == 0: set `fb_rd_row` = nv/SCALE, assert `fb_rd_req`, go to REQ.
  - **Acknowledge.** In REQ, on `fb_rd_ack`: load `linebuf` ← `fb_rd_data`, drop `fb_rd_req` the next cycle, go to IDLE.
  - **Deadline.** If still in REQ on the `ce_pix` where `hcnt` wraps to 0:
    - drop `fb_rd_req` and go to IDLE;
    - set `underrun`;
    - keep the previous `linebuf`, so the stale row is displayed;
    - ignore any late ack.
  - `fb_rd_ack` while in IDLE is ignored.
  - The row-0 fetch occurs on line V_TOT-1.
- **Frame start.** `frame_start` pulses for one `clk` on the `ce_pix` where `vcnt` becomes ACT and `hcnt` becomes 0.
- **Simultaneous events.** An ack in the same cycle as the deadline is accepted: the data loads and `underrun` is not set.

## Timing
- **Reset values.**
  - `ce_pix`, `hsync`, `vsync`, `fb_rd_req`, `frame_start` and `underrun` = 0.
  - `hblank` and `vblank` = 0.
  - `r`, `g`, `b` = 0.
  - `fb_rd_row` = 0, `linebuf` = 0, all counters = 0.
- **First pulse.** The first `ce_pix` occurs CE_DIV cycles after reset release.
- **Output latency.** Video outputs change 1 `clk` after `ce_pix`.
- **Fetch window.** `fb_rd_req` rises 1 `clk` after the triggering `ce_pix`. Available acknowledge window = (H_TOT−ACT)·CE_DIV−1 clk (383 at defaults).
- **Reset mid-operation.** Asserting `reset_n` low at any point returns everything to reset values immediately and abandons any pending request. `underrun` is cleared only by reset.
- **Frame period.** H_TOT·V_TOT·CE_DIV = 394 240 clk at defaults.

## Test plan
- **Reset and divider.** Hold `reset_n` low, then release. All outputs are 0. `ce_pix` pulses first at cycle 4 after release, then every 4 cycles.
- **Timing.** Count `ce_pix` pulses over one frame.
  - `hblank` is low for 256 of every 352 pulses.
  - `hsync` is high for 32 pulses, starting at `hcnt` = 272.
  - `vsync` is high on lines 260–263.
  - `frame_start` fires once per 280 lines.
- **Fetch sequence.** The acking model responds with `fb_rd_data` = row index replicated. Over one frame, requests occur for rows 0..31 in order, one per 8 lines, issued on lines 279, 7, 15, …, 247. No request occurs on other lines.
- **Pixel mapping.** Supply row 5 = 0x0000_0001 and all other rows = 0.
  - Lines 40–47, `hcnt` 0–7 output (0x20,0x28,0x20).
  - Every other active pixel outputs (0xB0,0xC0,0xA0).
  - Blanking outputs 0.
- **Underrun.** Withhold the ack for row 3.
  - `fb_rd_req` drops at the line-24 boundary.
  - `underrun` rises and stays high.
  - Lines 24–31 show row 2 data.
  - An ack arriving afterwards is ignored.
- **Edge ack and mid-frame reset.**
  - An ack arriving exactly at the deadline cycle loads the data with no `underrun`.
  - Asserting reset while `fb_rd_req` is high drops the request and counters asynchronously.
